// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types and AXI field constants for the read-channel arbiter
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;

    localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'b00;
    localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way one-hot grant; round-robin when AXI_ARB_RR_EN is defined, else fixed priority
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

`ifdef AXI_ARB_RR_EN
    logic [IDX_W-1:0] ptr;

    // Pointer moves past the master that just finished, so it gets lowest priority next.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(last_idx) == N-1) ? '0 : last_idx + 1'b1;
        end
    end

    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IDX_W'(idx);
            end
        end
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clock, reset, advance, last_idx};

    // Descending scan so the lowest requesting index is the last (winning) write.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (req[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - N-master AXI read (AR+R) arbiter, one outstanding burst; AXI_ARB_RR_EN selects round-robin
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int N_MASTER = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ID_W     = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [N_MASTER-1:0]             m_arvalid,
    output logic [N_MASTER-1:0]             m_arready,
    input  logic [N_MASTER*ADDR_W-1:0]      m_araddr,
    input  logic [N_MASTER*ID_W-1:0]        m_arid,
    input  logic [N_MASTER*AXI_LEN_W-1:0]   m_arlen,
    input  logic [N_MASTER*AXI_SIZE_W-1:0]  m_arsize,
    input  logic [N_MASTER*AXI_BURST_W-1:0] m_arburst,
    output logic [N_MASTER-1:0]             m_rvalid,
    input  logic [N_MASTER-1:0]             m_rready,
    output logic [DATA_W-1:0]               m_rdata,
    output logic [1:0]                      m_rresp,
    output logic                            m_rlast,
    output logic [ID_W-1:0]                 m_rid,
    output logic                            s_arvalid,
    input  logic                            s_arready,
    output logic [ADDR_W-1:0]               s_araddr,
    output logic [ID_W-1:0]                 s_arid,
    output logic [AXI_LEN_W-1:0]            s_arlen,
    output logic [AXI_SIZE_W-1:0]           s_arsize,
    output logic [AXI_BURST_W-1:0]          s_arburst,
    input  logic                            s_rvalid,
    output logic                            s_rready,
    input  logic [DATA_W-1:0]               s_rdata,
    input  logic [1:0]                      s_rresp,
    input  logic                            s_rlast,
    input  logic [ID_W-1:0]                 s_rid,
    output logic                            len_err
);

    localparam int IDX_W = $clog2(N_MASTER);

    arb_state_e               state, state_nxt;
    logic [IDX_W-1:0]         g_q, win_idx;
    logic [N_MASTER-1:0]      win_oh;
    logic                     any_req, beat, last_beat;
    logic [ADDR_W-1:0]        addr_q;
    logic [ID_W-1:0]          id_q;
    logic [AXI_LEN_W-1:0]     len_q, beat_cnt;
    logic [AXI_SIZE_W-1:0]    size_q;
    logic [AXI_BURST_W-1:0]   burst_q;
    logic                     ovf_seen;

    assign any_req   = |m_arvalid;
    assign beat      = (state == DATA) && s_rvalid && s_rready;
    assign last_beat = beat && s_rlast;

    rr_arbiter #(
        .N     (N_MASTER),
        .IDX_W (IDX_W)
    ) u_rr (
        .clock     (clock),
        .reset     (reset),
        .req       (m_arvalid),
        .advance   (last_beat),
        .last_idx  (g_q),
        .grant     (win_oh),
        .grant_idx (win_idx)
    );

    always_comb begin
        state_nxt = state;
        m_arready = '0;
        m_rvalid  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    m_arready = reset ? '0 : win_oh;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                s_arvalid = 1'b1;
                if (s_arready) state_nxt = DATA;
            end
            DATA: begin
                s_rready      = m_rready[g_q];
                m_rvalid[g_q] = s_rvalid;
                if (s_rvalid && m_rready[g_q] && s_rlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s_araddr  = addr_q;
    assign s_arid    = id_q;
    assign s_arlen   = len_q;
    assign s_arsize  = size_q;
    assign s_arburst = burst_q;

    assign m_rdata = s_rdata;
    assign m_rresp = s_rresp;
    assign m_rlast = s_rlast;
    assign m_rid   = s_rid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            g_q      <= '0;
            addr_q   <= '0;
            id_q     <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            beat_cnt <= '0;
            ovf_seen <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            len_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        g_q     <= win_idx;
                        addr_q  <= m_araddr[win_idx*ADDR_W +: ADDR_W];
                        id_q    <= m_arid[win_idx*ID_W +: ID_W];
                        len_q   <= m_arlen[win_idx*AXI_LEN_W +: AXI_LEN_W];
                        size_q  <= m_arsize[win_idx*AXI_SIZE_W +: AXI_SIZE_W];
                        burst_q <= m_arburst[win_idx*AXI_BURST_W +: AXI_BURST_W];
                    end
                end
                ADDR: begin
                    if (s_arready) begin
                        beat_cnt <= '0;
                        ovf_seen <= 1'b0;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        // One error report per burst: an overrun already flagged suppresses the rlast check.
                        if (s_rlast) begin
                            len_err <= (beat_cnt != len_q) && !ovf_seen;
                        end else if ((beat_cnt == len_q) && !ovf_seen) begin
                            len_err  <= 1'b1;
                            ovf_seen <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - self-checking bench for axi_rd_arbiter (N_MASTER=4, DATA_W=64)
module tb_axi_rd_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    m_arvalid = '0;
    logic [N-1:0]    m_arready;
    logic [N*AW-1:0] m_araddr = '0;
    logic [N*IW-1:0] m_arid = '0;
    logic [N*8-1:0]  m_arlen = '0;
    logic [N*3-1:0]  m_arsize = '0;
    logic [N*2-1:0]  m_arburst = '0;
    logic [N-1:0]    m_rvalid;
    logic [N-1:0]    m_rready = '0;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;
    logic [IW-1:0]   m_rid;
    logic            s_arvalid;
    logic            s_arready = 1'b0;
    logic [AW-1:0]   s_araddr;
    logic [IW-1:0]   s_arid;
    logic [7:0]      s_arlen;
    logic [2:0]      s_arsize;
    logic [1:0]      s_arburst;
    logic            s_rvalid = 1'b0;
    logic            s_rready;
    logic [DW-1:0]   s_rdata = '0;
    logic [1:0]      s_rresp = '0;
    logic            s_rlast = 1'b0;
    logic [IW-1:0]   s_rid = '0;
    logic            len_err;

    axi_rd_arbiter #(
        .N_MASTER (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .ID_W     (IW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_araddr  (m_araddr),
        .m_arid    (m_arid),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
        .m_rid     (m_rid),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_arid    (s_arid),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arburst (s_arburst),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rid     (s_rid),
        .len_err   (len_err)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int ptr    = 0;

    logic [AW-1:0] addr  [N];
    logic [IW-1:0] id    [N];
    logic [7:0]    len   [N];
    logic [2:0]    size  [N];
    logic [1:0]    burst [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference arbitration: scan from the pointer (RR) or from index 0 (fixed priority).
    function automatic int pick(input logic [N-1:0] r);
`ifdef AXI_ARB_RR_EN
        for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
`else
        for (int k = 0; k < N; k++) if (r[k]) return k;
`endif
        return 0;
    endfunction

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            m_araddr[i*AW +: AW] = addr[i];
            m_arid[i*IW +: IW]   = id[i];
            m_arlen[i*8 +: 8]    = len[i];
            m_arsize[i*3 +: 3]   = size[i];
            m_arburst[i*2 +: 2]  = burst[i];
        end
    endtask

    task automatic set_master(input int i, input logic [AW-1:0] a, input logic [7:0] l);
        addr[i]  = a;
        id[i]    = IW'($urandom);
        len[i]   = l;
        size[i]  = 3'(2 + $urandom_range(0, 1));
        burst[i] = 2'b01;
        pack();
    endtask

    // One complete burst from the current IDLE cycle; 'early' shortens the slave's burst by that many beats.
    task automatic do_burst(input bit keep, input int early, input int stall_at, input int stall_n, input bit rnd_rdy);
        int w, nbeats, b, cyc, stalled, waits;
        logic rdy;
        w = pick(m_arvalid);
        nbeats = int'(len[w]) + 1 - early;
        #1 chk("arready_grant", 64'(m_arready), 64'(oh(w)));
        step();
        if (!keep) m_arvalid[w] = 1'b0;
        waits = $urandom_range(0, 2);
        for (int i = 0; i < waits; i++) begin
            #1 chk("arvalid_wait", 64'(s_arvalid), 64'(1));
            chk("araddr_wait", 64'(s_araddr), 64'(addr[w]));
            step();
        end
        s_arready = 1'b1;
        #1 chk("arvalid", 64'(s_arvalid), 64'(1));
        chk("araddr", 64'(s_araddr), 64'(addr[w]));
        chk("arid", 64'(s_arid), 64'(id[w]));
        chk("arlen", 64'(s_arlen), 64'(len[w]));
        chk("arsize", 64'(s_arsize), 64'(size[w]));
        chk("arburst", 64'(s_arburst), 64'(burst[w]));
        chk("arready_in_addr", 64'(m_arready), 64'(0));
        step();
        s_arready = 1'b0;
        b = 0; cyc = 0; stalled = 0;
        while (b < nbeats && cyc < 2000) begin
            s_rvalid = 1'b1;
            s_rdata  = {$urandom, $urandom};
            s_rresp  = 2'($urandom);
            s_rid    = id[w];
            s_rlast  = (b == nbeats - 1);
            if (stall_n > 0 && b == stall_at && stalled < stall_n) begin
                rdy = 1'b0;
                stalled++;
            end else if (rnd_rdy) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            m_rready    = N'($urandom);
            m_rready[w] = rdy;
            #1 chk("rvalid_route", 64'(m_rvalid), 64'(oh(w)));
            chk("rready_pass", 64'(s_rready), 64'(rdy));
            chk("rdata", m_rdata, s_rdata);
            chk("rresp", 64'(m_rresp), 64'(s_rresp));
            chk("rlast", 64'(m_rlast), 64'(s_rlast));
            chk("rid", 64'(m_rid), 64'(id[w]));
            if (rdy) b++;
            cyc++;
            step();
        end
        chk("beats_delivered", 64'(b), 64'(nbeats));
        if (stall_n > 0) chk("stall_cycles", 64'(cyc), 64'(nbeats + stall_n));
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        m_rready = '0;
        #1 chk("len_err", 64'(len_err), 64'(early != 0));
        chk("idle_rvalid", 64'(m_rvalid), 64'(0));
        chk("idle_rready", 64'(s_rready), 64'(0));
        chk("idle_arvalid", 64'(s_arvalid), 64'(0));
        ptr = (w + 1) % N;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [N-1:0] newm;
        for (int i = 0; i < N; i++) set_master(i, AW'($urandom), 8'd0);

        repeat (2) @(posedge clock);
        #2;
        chk("rst_arready", 64'(m_arready), 64'(0));
        chk("rst_arvalid", 64'(s_arvalid), 64'(0));
        chk("rst_rready", 64'(s_rready), 64'(0));
        chk("rst_rvalid", 64'(m_rvalid), 64'(0));
        chk("rst_len_err", 64'(len_err), 64'(0));
        reset = 1'b0;
        step();

        // Single master 1, arlen=3.
        set_master(1, 32'h8000_0000, 8'd3);
        m_arvalid = 4'b0010;
        do_burst(1'b0, 0, -1, 0, 1'b0);

        // Masters 0 and 1 contending continuously, single-beat bursts.
        set_master(0, AW'($urandom), 8'd0);
        set_master(1, AW'($urandom), 8'd0);
        m_arvalid = 4'b0011;
        for (int k = 0; k < 8; k++) do_burst(1'b1, 0, -1, 0, 1'b0);
        m_arvalid = '0;
        step();

        // Back-pressure for 5 cycles mid-burst on master 2.
        set_master(2, AW'($urandom), 8'd7);
        m_arvalid = 4'b0100;
        do_burst(1'b0, 0, 3, 5, 1'b0);

        // Early rlast: three beats for arlen=3.
        set_master(3, AW'($urandom), 8'd3);
        m_arvalid = 4'b1000;
        do_burst(1'b0, 1, -1, 0, 1'b0);
        step();
        chk("len_err_one_cycle", 64'(len_err), 64'(0));

        // Missing rlast: 256 beats against arlen=3.
        set_master(0, AW'($urandom), 8'd3);
        m_arvalid = 4'b0001;
        step();
        m_arvalid = '0;
        s_arready = 1'b1;
        step();
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rlast   = 1'b0;
        m_rready  = '1;
        pulses    = 0;
        for (int i = 0; i < 256; i++) begin
            #1 if (len_err) pulses++;
            step();
        end
        #1 if (len_err) pulses++;
        chk("ovf_pulses", 64'(pulses), 64'(1));
        chk("ovf_stays_data", 64'(s_rready), 64'(1));
        chk("ovf_rvalid", 64'(m_rvalid), 64'(oh(0)));
        reset = 1'b1;
        step();
        reset = 1'b0; s_rvalid = 1'b0; m_rready = '0; ptr = 0;
        step();

        // Reset during ADDR with s_arready low.
        set_master(2, AW'($urandom), 8'd1);
        m_arvalid = 4'b0100;
        step();
        m_arvalid = 4'b0010;
        #1 chk("pre_rst_arvalid", 64'(s_arvalid), 64'(1));
        reset = 1'b1;
        #1 chk("rstA_arvalid", 64'(s_arvalid), 64'(0));
        chk("rstA_rready", 64'(s_rready), 64'(0));
        chk("rstA_rvalid", 64'(m_rvalid), 64'(0));
        chk("rstA_arready", 64'(m_arready), 64'(0));
        step();
        reset = 1'b0; m_arvalid = '0; ptr = 0;
        step();

        // Reset during DATA beat 1.
        set_master(1, AW'($urandom), 8'd3);
        m_arvalid = 4'b0010;
        step();
        m_arvalid = '0;
        s_arready = 1'b1;
        step();
        s_arready = 1'b0; s_rvalid = 1'b1; m_rready = '1;
        step();
        #1 chk("pre_rst_rvalid", 64'(m_rvalid), 64'(oh(1)));
        reset = 1'b1;
        #1 chk("rstD_arvalid", 64'(s_arvalid), 64'(0));
        chk("rstD_rready", 64'(s_rready), 64'(0));
        chk("rstD_rvalid", 64'(m_rvalid), 64'(0));
        chk("rstD_len_err", 64'(len_err), 64'(0));
        step();
        reset = 1'b0; s_rvalid = 1'b0; m_rready = '0; ptr = 0;
        step();

        // Fresh request after reset, master 3 with arlen=1 on the wide build.
        set_master(3, AW'($urandom), 8'd1);
        m_arvalid = 4'b1000;
        do_burst(1'b0, 0, -1, 0, 1'b0);

        // Randomized contention with AXI-style held requests.
        for (int it = 0; it < 12; it++) begin
            newm = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++)
                if (newm[i] && !m_arvalid[i]) set_master(i, AW'($urandom), 8'($urandom_range(0, 5)));
            m_arvalid = m_arvalid | newm;
            do_burst(1'b0, 0, -1, 0, 1'b1);
        end
        for (int it = 0; it < N && m_arvalid != '0; it++) do_burst(1'b0, 0, -1, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
